// File: rtl/cpu_datapath_if.sv
// Control strobes and observation bundle for the bus-based CPU datapath.
// The control unit (or bench) is the master; the datapath is the slave.
interface cpu_datapath_if;
    logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, IncPC, write;
    logic [31:0] inportInput;
    logic [15:0] regIn;

    logic [31:0] busMuxOut;
    logic [4:0]  encoderOut;
    logic        CON;
    logic [31:0] BusMuxInR [16];
    logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC;
    logic [31:0] BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY;
    logic [31:0] IRregister, Cregister;
    logic [8:0]  marToRam;

    modport master (
        output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin,
        output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
        output Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
        input  busMuxOut, encoderOut, CON, BusMuxInR,
        input  BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC,
        input  BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY,
        input  IRregister, Cregister, marToRam
    );

    modport slave (
        input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin,
        input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
        output busMuxOut, encoderOut, CON, BusMuxInR,
        output BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC,
        output BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY,
        output IRregister, Cregister, marToRam
    );
endinterface

// File: rtl/cpu_datapath.sv
// 32-bit single-bus CPU datapath: 16x32 register file, special registers,
// ALU with 64-bit Z, and a RAM addressed by MAR. One T-step per rising edge.
module cpu_datapath #(
    parameter int unsigned MEM_DEPTH = 512
) (
    input  logic          Clock,
    input  logic          Clear,
    cpu_datapath_if.slave bus_if
);
    localparam logic [4:0] OP_SUB  = 5'b00100, OP_AND  = 5'b00101, OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111, OP_SHRA = 5'b01000, OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010, OP_ROL  = 5'b01011, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_OUT  = 5'b10111;

    logic [31:0] r_q [16];
    logic [31:0] hi_q, lo_q, pc_q, mdr_q, inport_q, outport_q, y_q, ir_q;
    logic [63:0] z_q, z_d;
    logic [8:0]  mar_q;
    logic        con_q, con_d;
    logic [31:0] mem_q [MEM_DEPTH];
    logic [31:0] mdr_d, bus_s, c_s, ram_rd_s;
    logic [15:0] sel_s, r_en_s;
    logic [31:0] req_s;
    logic [4:0]  enc_s, op_s, shamt_s;
    logic [63:0] prod_s, rot_s;
    logic [31:0] quot_s, rem_s;

    assign op_s     = ir_q[31:27];
    assign c_s      = {{13{ir_q[18]}}, ir_q[18:0]};
    assign ram_rd_s = mem_q[mar_q];
    assign shamt_s  = bus_s[4:0];

    // Register-field decode, per-register load enables and bus requests
    always_comb begin
        req_s = 32'd0;
        for (int i = 0; i < 16; i++) begin
            sel_s[i]  = (bus_if.Gra && (ir_q[26:23] == 4'(i))) ||
                        (bus_if.Grb && (ir_q[22:19] == 4'(i))) ||
                        (bus_if.Grc && (ir_q[18:15] == 4'(i)));
            r_en_s[i] = bus_if.regIn[i] | (bus_if.Rin & sel_s[i]);
            req_s[i]  = (bus_if.Rout | bus_if.BAout) & sel_s[i];
        end
        req_s[16] = bus_if.HIout;   req_s[17] = bus_if.LOout;
        req_s[18] = bus_if.ZHIout;  req_s[19] = bus_if.ZLOout;
        req_s[20] = bus_if.PCout;   req_s[21] = bus_if.MDRout;
        req_s[22] = bus_if.INPORTout; req_s[23] = bus_if.Cout;
        req_s[24] = bus_if.Yout;    req_s[25] = bus_if.OUTPORTout;
    end

    // Priority encoder: lowest active code wins, 31 when idle
    always_comb begin
        enc_s = 5'd31;
        for (int i = 31; i >= 0; i--) begin
            if (req_s[i]) enc_s = 5'(i);
            else          enc_s = enc_s;
        end
    end

    // Bus multiplexer; BAout forces R0 to read as zero
    always_comb begin
        bus_s = 32'd0;
        if (enc_s < 5'd16) begin
            if ((enc_s == 5'd0) && bus_if.BAout) bus_s = 32'd0;
            else                                 bus_s = r_q[enc_s[3:0]];
        end else begin
            case (enc_s)
                5'd16:   bus_s = hi_q;
                5'd17:   bus_s = lo_q;
                5'd18:   bus_s = z_q[63:32];
                5'd19:   bus_s = z_q[31:0];
                5'd20:   bus_s = pc_q;
                5'd21:   bus_s = mdr_q;
                5'd22:   bus_s = inport_q;
                5'd23:   bus_s = c_s;
                5'd24:   bus_s = y_q;
                5'd25:   bus_s = outport_q;
                default: bus_s = 32'd0;
            endcase
        end
    end

    // Wide/signed ALU helpers (A = Y, B = bus)
    always_comb begin
        prod_s = {{32{y_q[31]}}, y_q} * {{32{bus_s[31]}}, bus_s};
        rot_s  = {y_q, y_q};
        if (bus_s == 32'd0) begin
            quot_s = 32'd0;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(y_q) / $signed(bus_s);
            rem_s  = $signed(y_q) % $signed(bus_s);
        end
    end

    // ALU result for Z; IncPC overrides the opcode
    always_comb begin
        z_d = 64'd0;
        if (bus_if.IncPC) begin
            z_d = {32'd0, pc_q + 32'd1};
        end else begin
            case (op_s)
                OP_SUB:         z_d = {32'd0, y_q - bus_s};
                OP_AND, OP_ANDI: z_d = {32'd0, y_q & bus_s};
                OP_OR,  OP_ORI:  z_d = {32'd0, y_q | bus_s};
                OP_SHR:         z_d = {32'd0, y_q >> shamt_s};
                OP_SHRA:        z_d = {32'd0, 32'($signed(y_q) >>> shamt_s)};
                OP_SHL:         z_d = {32'd0, y_q << shamt_s};
                OP_ROR:         z_d = {32'd0, 32'(rot_s >> shamt_s)};
                OP_ROL:         z_d = {32'd0, 32'((rot_s << shamt_s) >> 32)};
                OP_MUL:         z_d = prod_s;
                OP_DIV:         z_d = {rem_s, quot_s};
                OP_NEG:         z_d = {32'd0, 32'd0 - bus_s};
                OP_NOT:         z_d = {32'd0, ~bus_s};
                default:        z_d = {32'd0, y_q + bus_s};
            endcase
        end
    end

    // MDR source and branch condition
    always_comb begin
        if (bus_if.Read) mdr_d = ram_rd_s;
        else             mdr_d = bus_s;
        case (ir_q[20:19])
            2'b00:   con_d = (bus_s == 32'd0);
            2'b01:   con_d = (bus_s != 32'd0);
            2'b10:   con_d = ~bus_s[31];
            2'b11:   con_d = bus_s[31];
            default: con_d = 1'b0;
        endcase
    end

    // Architectural registers; Clear has priority over every enable
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= 32'd0;
            hi_q <= 32'd0;  lo_q <= 32'd0;  pc_q <= 32'd0;  mdr_q <= 32'd0;
            inport_q <= 32'd0;  outport_q <= 32'd0;  y_q <= 32'd0;  ir_q <= 32'd0;
            z_q <= 64'd0;  mar_q <= 9'd0;  con_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) if (r_en_s[i]) r_q[i] <= bus_s;
            if (bus_if.HIin)  hi_q  <= bus_s;
            if (bus_if.LOin)  lo_q  <= bus_s;
            if (bus_if.PCin)  pc_q  <= bus_s;
            if (bus_if.MDRin) mdr_q <= mdr_d;
            if (bus_if.Yin)   y_q   <= bus_s;
            if (bus_if.IRin)  ir_q  <= bus_s;
            if (bus_if.Zin)   z_q   <= z_d;
            if (bus_if.MARin) mar_q <= bus_s[8:0];
            if (bus_if.CONin) con_q <= con_d;
            if (bus_if.Gra && bus_if.Rout && (op_s == OP_OUT)) outport_q <= bus_s;
            inport_q <= bus_if.inportInput;
        end
    end

    // RAM write uses the MDR value held before this edge
    always_ff @(posedge Clock) begin
        if (bus_if.write) mem_q[mar_q] <= mdr_q;
    end

    assign bus_if.busMuxOut       = bus_s;
    assign bus_if.encoderOut      = enc_s;
    assign bus_if.CON             = con_q;
    assign bus_if.BusMuxInR       = r_q;
    assign bus_if.BusMuxInHI      = hi_q;
    assign bus_if.BusMuxInLO      = lo_q;
    assign bus_if.BusMuxInZhi     = z_q[63:32];
    assign bus_if.BusMuxInZlo     = z_q[31:0];
    assign bus_if.BusMuxInPC      = pc_q;
    assign bus_if.BusMuxInMDR     = mdr_q;
    assign bus_if.BusMuxInInport  = inport_q;
    assign bus_if.BusMuxInOutport = outport_q;
    assign bus_if.BusMuxInY       = y_q;
    assign bus_if.IRregister      = ir_q;
    assign bus_if.Cregister       = c_s;
    assign bus_if.marToRam        = mar_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: expectations are queued as each T-step is
// driven and popped against the observed register after the step's edge.
module tb_cpu_datapath;
    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    string       tag_q [$];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_datapath_if dp_if ();
    cpu_datapath #(.MEM_DEPTH(512)) dut (.Clock(clk), .Clear(clear), .bus_if(dp_if.slave));

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            check_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic idle();
        dp_if.HIin = 1'b0; dp_if.LOin = 1'b0; dp_if.PCin = 1'b0; dp_if.MDRin = 1'b0;
        dp_if.Zin = 1'b0; dp_if.Yin = 1'b0; dp_if.MARin = 1'b0; dp_if.IRin = 1'b0;
        dp_if.CONin = 1'b0; dp_if.HIout = 1'b0; dp_if.LOout = 1'b0; dp_if.ZHIout = 1'b0;
        dp_if.ZLOout = 1'b0; dp_if.PCout = 1'b0; dp_if.MDRout = 1'b0; dp_if.INPORTout = 1'b0;
        dp_if.OUTPORTout = 1'b0; dp_if.Cout = 1'b0; dp_if.Yout = 1'b0; dp_if.Gra = 1'b0;
        dp_if.Grb = 1'b0; dp_if.Grc = 1'b0; dp_if.Rin = 1'b0; dp_if.Rout = 1'b0;
        dp_if.BAout = 1'b0; dp_if.Read = 1'b0; dp_if.IncPC = 1'b0; dp_if.write = 1'b0;
        dp_if.regIn = 16'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Y <- a, IR <- op, then Z <- ALU(Y, b) using the inport pipeline
    task automatic alu_case(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
        idle();
        dp_if.inportInput = a;                  tick();
        dp_if.INPORTout = 1'b1; dp_if.Yin = 1'b1;
        dp_if.inportInput = {op, 27'd0};        tick(); idle();
        dp_if.INPORTout = 1'b1; dp_if.IRin = 1'b1;
        dp_if.inportInput = b;                  tick(); idle();
        dp_if.INPORTout = 1'b1; dp_if.Zin = 1'b1;
        sb_push(tag, exp);                      tick(); idle();
        sb_pop({dp_if.BusMuxInZhi, dp_if.BusMuxInZlo});
    endtask

    task automatic con_case(input string tag, input logic [31:0] ir, input logic [31:0] b,
                            input logic exp);
        idle();
        dp_if.inportInput = ir;                 tick();
        dp_if.INPORTout = 1'b1; dp_if.IRin = 1'b1;
        dp_if.inportInput = b;                  tick(); idle();
        dp_if.INPORTout = 1'b1; dp_if.CONin = 1'b1;
        sb_push(tag, 64'(exp));                 tick(); idle();
        sb_pop(64'(dp_if.CON));
    endtask

    initial begin
        clear = 1'b1;
        dp_if.inportInput = 32'd0;
        idle();
        tick(); tick();
        clear = 1'b0;
        check_val("rst_r4",  64'(dp_if.BusMuxInR[4]), 64'd0);
        check_val("rst_pc",  64'(dp_if.BusMuxInPC), 64'd0);
        check_val("rst_z",   {dp_if.BusMuxInZhi, dp_if.BusMuxInZlo}, 64'd0);
        check_val("rst_con", 64'(dp_if.CON), 64'd0);
        check_val("idle_enc", 64'(dp_if.encoderOut), 64'd31);
        check_val("idle_bus", 64'(dp_if.busMuxOut), 64'd0);

        // Place the instruction word 0x12200090 at RAM[5] through the datapath
        dp_if.inportInput = 32'd5;              tick();
        dp_if.INPORTout = 1'b1; dp_if.MARin = 1'b1;
        dp_if.inportInput = 32'h1220_0090;      tick(); idle();
        dp_if.INPORTout = 1'b1; dp_if.MDRin = 1'b1; tick(); idle();
        dp_if.write = 1'b1;                     tick(); idle();

        // Preload R4 = 22 and PC = 5
        dp_if.inportInput = 32'd22;             tick();
        dp_if.INPORTout = 1'b1; dp_if.regIn = 16'h0010;
        dp_if.inportInput = 32'd5;
        sb_push("r4_load", 64'd22);             tick(); idle();
        sb_pop(64'(dp_if.BusMuxInR[4]));
        dp_if.INPORTout = 1'b1; dp_if.PCin = 1'b1;
        sb_push("pc_load", 64'd5);              tick(); idle();
        sb_pop(64'(dp_if.BusMuxInPC));

        // Fetch
        dp_if.PCout = 1'b1; dp_if.MARin = 1'b1; dp_if.IncPC = 1'b1; dp_if.Zin = 1'b1;
        sb_push("t0_mar", 64'd5);
        sb_push("t0_z", 64'd6);                 tick(); idle();
        sb_pop(64'(dp_if.marToRam));
        sb_pop({dp_if.BusMuxInZhi, dp_if.BusMuxInZlo});
        dp_if.Read = 1'b1; dp_if.MDRin = 1'b1;
        sb_push("t1_mdr", 64'h1220_0090);       tick(); idle();
        sb_pop(64'(dp_if.BusMuxInMDR));
        dp_if.MDRout = 1'b1; dp_if.IRin = 1'b1;
        sb_push("t2_ir", 64'h1220_0090);
        sb_push("c_sext", 64'h90);              tick(); idle();
        sb_pop(64'(dp_if.IRregister));
        sb_pop(64'(dp_if.Cregister));

        // st 0x90(R4),R4
        dp_if.Grb = 1'b1; dp_if.BAout = 1'b1; dp_if.Yin = 1'b1;
        sb_push("st_y", 64'd22);                tick(); idle();
        sb_pop(64'(dp_if.BusMuxInY));
        dp_if.Cout = 1'b1; dp_if.Zin = 1'b1;
        sb_push("st_z", 64'hA6);                tick(); idle();
        sb_pop({dp_if.BusMuxInZhi, dp_if.BusMuxInZlo});
        dp_if.ZLOout = 1'b1; dp_if.MARin = 1'b1;
        sb_push("st_mar", 64'd166);             tick(); idle();
        sb_pop(64'(dp_if.marToRam));
        dp_if.Gra = 1'b1; dp_if.Rout = 1'b1; dp_if.MDRin = 1'b1;
        sb_push("st_mdr", 64'd22);              tick(); idle();
        sb_pop(64'(dp_if.BusMuxInMDR));
        // write while MDR reloads: RAM must take the old MDR (22)
        dp_if.write = 1'b1; dp_if.PCout = 1'b1; dp_if.MDRin = 1'b1;
        sb_push("mdr_reload", 64'd5);           tick(); idle();
        sb_pop(64'(dp_if.BusMuxInMDR));

        // Bus arbitration
        dp_if.PCout = 1'b1; dp_if.MDRout = 1'b1; #1;
        check_val("arb_enc", 64'(dp_if.encoderOut), 64'd20);
        check_val("arb_bus", 64'(dp_if.busMuxOut), 64'd5);
        idle(); #1;
        check_val("none_enc", 64'(dp_if.encoderOut), 64'd31);
        check_val("none_bus", 64'(dp_if.busMuxOut), 64'd0);
        tick();

        // BAout with Rb = 0 reads zero; Rout reads R0 itself
        dp_if.inportInput = 32'h77;             tick();
        dp_if.INPORTout = 1'b1; dp_if.regIn = 16'h0001;
        dp_if.inportInput = 32'h1200_0090;      tick(); idle();
        dp_if.INPORTout = 1'b1; dp_if.IRin = 1'b1; tick(); idle();
        dp_if.Grb = 1'b1; dp_if.BAout = 1'b1; dp_if.Yin = 1'b1; #1;
        check_val("ba_enc", 64'(dp_if.encoderOut), 64'd0);
        sb_push("ba_y", 64'd0);                 tick(); idle();
        sb_pop(64'(dp_if.BusMuxInY));
        dp_if.Cout = 1'b1; dp_if.Zin = 1'b1;    tick(); idle();
        dp_if.ZLOout = 1'b1; dp_if.MARin = 1'b1;
        sb_push("ba_mar", 64'h90);              tick(); idle();
        sb_pop(64'(dp_if.marToRam));
        dp_if.Grb = 1'b1; dp_if.Rout = 1'b1; dp_if.Yin = 1'b1;
        sb_push("rout_r0", 64'h77);             tick(); idle();
        sb_pop(64'(dp_if.BusMuxInY));

        // out R0 -> outport
        dp_if.inportInput = 32'hB800_0000;      tick();
        dp_if.INPORTout = 1'b1; dp_if.IRin = 1'b1; tick(); idle();
        dp_if.Gra = 1'b1; dp_if.Rout = 1'b1;
        sb_push("outport", 64'h77);             tick(); idle();
        sb_pop(64'(dp_if.BusMuxInOutport));

        // ALU
        alu_case("mul",    5'b01111, 32'hFFFF_FFFD, 32'd7,  64'hFFFF_FFFF_FFFF_FFEB);
        alu_case("sub",    5'b00100, 32'd10, 32'd3,         64'd7);
        alu_case("and",    5'b00101, 32'hF0F0, 32'hFF00,    64'hF000);
        alu_case("or",     5'b00110, 32'hF0F0, 32'hFF00,    64'hFFF0);
        alu_case("shr",    5'b00111, 32'h8000_0000, 32'h24, 64'h0800_0000);
        alu_case("shra",   5'b01000, 32'h8000_0000, 32'd4,  64'hF800_0000);
        alu_case("shl",    5'b01001, 32'd1, 32'd31,         64'h8000_0000);
        alu_case("ror",    5'b01010, 32'd1, 32'd1,          64'h8000_0000);
        alu_case("ror0",   5'b01010, 32'h1234, 32'd0,       64'h1234);
        alu_case("rol",    5'b01011, 32'h8000_0001, 32'd4,  64'h18);
        alu_case("div",    5'b10000, 32'hFFFF_FFF9, 32'd2,  64'hFFFF_FFFF_FFFF_FFFD);
        alu_case("div0",   5'b10000, 32'd9, 32'd0,          64'd0);
        alu_case("neg",    5'b10001, 32'd9, 32'd5,          64'hFFFF_FFFB);
        alu_case("not",    5'b10010, 32'd9, 32'd0,          64'hFFFF_FFFF);
        alu_case("addwrap",5'b00011, 32'hFFFF_FFFF, 32'd1,  64'd0);
        alu_case("addi",   5'b01100, 32'h10, 32'h20,        64'h30);

        // Branch condition
        con_case("con_neg",   32'h0018_0000, 32'h8000_0000, 1'b1);
        con_case("con_pos",   32'h0018_0000, 32'h0000_0001, 1'b0);
        con_case("con_zero",  32'h0000_0000, 32'h0000_0000, 1'b1);
        con_case("con_nz",    32'h0008_0000, 32'h0000_0000, 1'b0);

        // Clear beats simultaneous enables
        idle();
        dp_if.inportInput = 32'hABCD;           tick();
        clear = 1'b1;
        dp_if.INPORTout = 1'b1; dp_if.PCin = 1'b1; dp_if.Zin = 1'b1;
        dp_if.CONin = 1'b1; dp_if.regIn = 16'hFFFF; dp_if.MARin = 1'b1;
        tick(); clear = 1'b0; idle();
        check_val("clr_r4",   64'(dp_if.BusMuxInR[4]), 64'd0);
        check_val("clr_pc",   64'(dp_if.BusMuxInPC), 64'd0);
        check_val("clr_z",    {dp_if.BusMuxInZhi, dp_if.BusMuxInZlo}, 64'd0);
        check_val("clr_con",  64'(dp_if.CON), 64'd0);
        check_val("clr_out",  64'(dp_if.BusMuxInOutport), 64'd0);
        check_val("clr_in",   64'(dp_if.BusMuxInInport), 64'd0);
        check_val("clr_mar",  64'(dp_if.marToRam), 64'd0);
        check_val("clr_ir",   64'(dp_if.IRregister), 64'd0);

        // RAM survives Clear
        dp_if.inportInput = 32'd166;            tick();
        dp_if.INPORTout = 1'b1; dp_if.MARin = 1'b1; tick(); idle();
        dp_if.Read = 1'b1; dp_if.MDRin = 1'b1;
        sb_push("ram_keep", 64'd22);            tick(); idle();
        sb_pop(64'(dp_if.BusMuxInMDR));

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
